// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch stage.
//   XLEN          : architectural register / address width
//   INSN_NOP      : canonical NOP (addi x0, x0, 0), shown on id_instruction after reset
//   fetch_state_t : fetch FSM states
//   fetch_entry_t : one queued {pc, instruction} pair
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSN_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry queue of fetch_entry_t between fetch and decode.
// Slot 0 is always the head, so empty reads simply keep showing the last head.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_entry (ignored when full unless popping the same cycle)
//   i_pop      : remove head (ignored when empty)
//   i_flush    : drop all entries; dominates push/pop
//   i_entry    : entry to write
//   o_count    : number of valid entries (0..2)
//   o_head     : head entry
module fetch_fifo
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_entry,
  output logic [1:0]   o_count,
  output fetch_entry_t o_head
);

  logic [1:0]   r_count;
  fetch_entry_t r_slot0;
  fetch_entry_t r_slot1;

  logic       w_pop;
  logic       w_push;
  logic [1:0] w_wr_idx;

  assign w_pop    = i_pop && (r_count != 2'd0);
  assign w_push   = i_push && ((r_count != 2'd2) || w_pop);
  // Write slot is the first free one after this cycle's pop has shifted the queue.
  assign w_wr_idx = r_count - {1'b0, w_pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_slot0 <= '{pc: '0, insn: INSN_NOP};
      r_slot1 <= '{pc: '0, insn: INSN_NOP};
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else begin
      if (w_pop && (r_count == 2'd2)) r_slot0 <= r_slot1;
      if (w_push) begin
        if (w_wr_idx == 2'd0) r_slot0 <= i_entry;
        else                  r_slot1 <= i_entry;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_count = r_count;
  assign o_head  = r_slot0;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads instruction memory combinationally,
// buffers {pc, instruction} pairs in a 2-entry queue and hands them to decode.
//   clk, rst_n        : clock, asynchronous active-low reset
//   imem_pc           : fetch address (the fetch PC register)
//   imem_instruction  : word returned for imem_pc
//   redirect_valid/pc : taken branch/jump target from execute
//   id_valid/id_ready : decode handshake on the queue head
//   id_pc, id_pc_plus4, id_instruction : head entry (and link value)
//   fault             : sticky misaligned-redirect / out-of-range fetch flag
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] id_instruction,
  output logic        fault
);

  localparam logic [29:0] LP_WORD_LIMIT = 30'(IMEM_WORDS);

  fetch_state_t    r_state;
  fetch_state_t    w_state_next;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] w_fetch_pc_next;

  logic         w_push;
  logic         w_pop;
  logic         w_flush;
  logic         w_in_range;
  logic [1:0]   w_count;
  fetch_entry_t w_head;
  fetch_entry_t w_new_entry;

  assign w_in_range  = r_fetch_pc[31:2] < LP_WORD_LIMIT;
  assign w_pop       = id_valid && id_ready;
  assign w_new_entry = '{pc: r_fetch_pc, insn: imem_instruction};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= BOOT;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_push          = 1'b0;
    w_flush         = 1'b0;
    unique case (r_state)
      BOOT: w_state_next = RUN;
      RUN: begin
        if (redirect_valid) begin
          // A head popped this cycle is already delivered; everything else is stale.
          w_flush = 1'b1;
          if (redirect_pc[1:0] != 2'b00) w_state_next = FAULT;
          else                           w_fetch_pc_next = redirect_pc;
        end else if (!w_in_range) begin
          w_state_next = FAULT;
        end else if ((w_count != 2'd2) || w_pop) begin
          w_push          = 1'b1;
          w_fetch_pc_next = r_fetch_pc + 32'd4;
        end
      end
      FAULT: begin
        // Terminal until reset; queued entries keep draining through the FIFO.
      end
      default: w_state_next = FAULT;
    endcase
  end

  fetch_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_entry (w_new_entry),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign imem_pc        = r_fetch_pc;
  assign id_valid       = (w_count != 2'd0);
  assign id_pc          = w_head.pc;
  assign id_pc_plus4    = w_head.pc + 32'd4;
  assign id_instruction = w_head.insn;
  assign fault          = (r_state == FAULT);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cycle table for streaming/backpressure/redirect/fault,
// a scoreboard of expected delivered pcs, and hand sequences for reset and end-of-memory.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_pc;
  logic [31:0] imem_instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instruction;
  logic        fault;

  logic [31:0] mem [64];
  logic [31:0] sb [$];
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        rst_n;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eimem;
    logic        efault;
  } vec_t;

  vec_t tbl [$];

  always #5 clk = ~clk;

  assign imem_instruction = (imem_pc[31:8] == 24'd0) ? mem[imem_pc[7:2]] : 32'hDEAD_BEEF;

  fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(64)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_pc          (imem_pc),
    .imem_instruction (imem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .id_valid         (id_valid),
    .id_ready         (id_ready),
    .id_pc            (id_pc),
    .id_pc_plus4      (id_pc_plus4),
    .id_instruction   (id_instruction),
    .fault            (fault)
  );

  function automatic vec_t mk(logic r, logic rdy, logic rv, logic [31:0] rpc,
                              logic ev, logic [31:0] epc, logic [31:0] eimem, logic efault);
    vec_t v;
    v.rst_n = r; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.eimem = eimem; v.efault = efault;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_pop();
    logic [31:0] e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_unexpected: got pc %h required no delivery", id_pc);
    end else begin
      e = sb.pop_front();
      chk("sb_pc", id_pc, e);
      chk("sb_insn", id_instruction, mem[e[7:2]]);
      chk("sb_plus4", id_pc_plus4, e + 32'd4);
    end
  endtask

  // Record a handshake that happens at the coming edge, then advance one cycle.
  task automatic tick();
    if (id_valid && id_ready) sb_pop();
    @(posedge clk);
    #1;
  endtask

  task automatic mid_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    chk({tag, "_valid"}, {31'd0, id_valid}, 32'd0);
    chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
    chk({tag, "_imem_pc"}, imem_pc, 32'h0);
    chk({tag, "_id_pc"}, id_pc, 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      rst_n          = tbl[i].rst_n;
      id_ready       = tbl[i].rdy;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      tick();
      chk($sformatf("row%0d_valid", i), {31'd0, id_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("row%0d_imem_pc", i), imem_pc, tbl[i].eimem);
      chk($sformatf("row%0d_fault", i), {31'd0, fault}, {31'd0, tbl[i].efault});
      if (tbl[i].ev) begin
        chk($sformatf("row%0d_id_pc", i), id_pc, tbl[i].epc);
        chk($sformatf("row%0d_insn", i), id_instruction, mem[tbl[i].epc[7:2]]);
        chk($sformatf("row%0d_plus4", i), id_pc_plus4, tbl[i].epc + 32'd4);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | i;
    mem[0]  = 32'h0050_0113;
    mem[1]  = 32'h0030_0193;
    mem[2]  = 32'h0031_8233;
    mem[12] = 32'h0030_0113;

    //        rst rdy rv rpc    ev epc    imem   flt
    // Session 1: streaming with decode always ready.
    tbl.push_back(mk(1, 1, 0, 0,     0, 0,     32'h00, 0)); // 0 BOOT->RUN
    tbl.push_back(mk(1, 1, 0, 0,     1, 32'h0, 32'h04, 0)); // 1 first valid
    tbl.push_back(mk(1, 1, 0, 0,     1, 32'h4, 32'h08, 0)); // 2
    tbl.push_back(mk(1, 1, 0, 0,     1, 32'h8, 32'h0C, 0)); // 3
    // Session 2: backpressure, redirect from full queue, misaligned redirect.
    tbl.push_back(mk(1, 0, 0, 0,     0, 0,     32'h00, 0)); // 4 BOOT->RUN
    tbl.push_back(mk(1, 0, 0, 0,     1, 32'h0, 32'h04, 0)); // 5 first valid
    tbl.push_back(mk(1, 0, 0, 0,     1, 32'h0, 32'h08, 0)); // 6 full
    tbl.push_back(mk(1, 0, 0, 0,     1, 32'h0, 32'h08, 0)); // 7
    tbl.push_back(mk(1, 0, 0, 0,     1, 32'h0, 32'h08, 0)); // 8
    tbl.push_back(mk(1, 0, 0, 0,     1, 32'h0, 32'h08, 0)); // 9
    tbl.push_back(mk(1, 0, 0, 0,     1, 32'h0, 32'h08, 0)); // 10
    tbl.push_back(mk(1, 1, 0, 0,     1, 32'h4, 32'h0C, 0)); // 11 push+pop full
    tbl.push_back(mk(1, 1, 0, 0,     1, 32'h8, 32'h10, 0)); // 12
    tbl.push_back(mk(1, 1, 0, 0,     1, 32'hC, 32'h14, 0)); // 13 full
    tbl.push_back(mk(1, 1, 1, 32'h30, 0, 0,    32'h30, 0)); // 14 redirect, pop 0xC
    tbl.push_back(mk(1, 1, 0, 0,     1, 32'h30, 32'h34, 0)); // 15 target
    tbl.push_back(mk(1, 1, 0, 0,     1, 32'h34, 32'h38, 0)); // 16
    tbl.push_back(mk(1, 0, 1, 32'h40, 0, 0,    32'h40, 0)); // 17 redirect
    tbl.push_back(mk(1, 0, 1, 32'h20, 0, 0,    32'h20, 0)); // 18 back-to-back
    tbl.push_back(mk(1, 0, 0, 0,     1, 32'h20, 32'h24, 0)); // 19 last wins
    tbl.push_back(mk(1, 0, 1, 32'h32, 0, 0,    32'h24, 1)); // 20 misaligned
    tbl.push_back(mk(1, 1, 1, 32'h10, 0, 0,    32'h24, 1)); // 21 ignored
    tbl.push_back(mk(1, 1, 0, 0,     0, 0,     32'h24, 1)); // 22 sticky

    rst_n = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_plus4", id_pc_plus4, 32'h4);
    chk("rst_insn", id_instruction, 32'h0000_0013);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_imem_pc", imem_pc, 32'h0);

    sb.push_back(32'h0); sb.push_back(32'h4);
    run_rows(0, 3);
    mid_reset("mr1");

    sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8);
    sb.push_back(32'hC); sb.push_back(32'h30);
    run_rows(4, 22);
    mid_reset("mr2");

    // End of memory with decode ready; a redirect during BOOT is ignored.
    rst_n = 1'b1; id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    chk("boot_redir_imem", imem_pc, 32'h0);
    chk("boot_redir_valid", {31'd0, id_valid}, 32'd0);
    redirect_pc = 32'hF8;
    tick();
    chk("eom_redir_imem", imem_pc, 32'hF8);
    chk("eom_redir_valid", {31'd0, id_valid}, 32'd0);
    redirect_valid = 1'b0;
    sb.push_back(32'hF8); sb.push_back(32'hFC);
    tick();
    chk("eom_pc_f8", id_pc, 32'hF8);
    tick();
    chk("eom_pc_fc", id_pc, 32'hFC);
    chk("eom_imem_100", imem_pc, 32'h100);
    chk("eom_fault_pre", {31'd0, fault}, 32'd0);
    tick();
    chk("eom_fault", {31'd0, fault}, 32'd1);
    chk("eom_valid", {31'd0, id_valid}, 32'd0);
    tick();
    chk("eom_imem_frozen", imem_pc, 32'h100);
    mid_reset("mr3");

    // End of memory with a full queue: fault raises, entries still drain.
    rst_n = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'hF8;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    chk("drain_imem", imem_pc, 32'h100);
    chk("drain_fault_pre", {31'd0, fault}, 32'd0);
    tick();
    chk("drain_fault", {31'd0, fault}, 32'd1);
    chk("drain_valid", {31'd0, id_valid}, 32'd1);
    chk("drain_head", id_pc, 32'hF8);
    id_ready = 1'b1;
    sb.push_back(32'hF8); sb.push_back(32'hFC);
    tick();
    chk("drain_head2", id_pc, 32'hFC);
    tick();
    chk("drain_empty", {31'd0, id_valid}, 32'd0);
    chk("drain_imem_frozen", imem_pc, 32'h100);

    chk("sb_all_delivered", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
